procm6_io_ctrl: RTL and testbench
=================================

Name: procm6_io_ctrl

Overview:
- Processor-side I/O controller for procm6: the core end of the sample-stream protocol.
- Generates the 2-bit input request strobe (req_in) and the 2-bit output enable strobe (out_en) toward the external sample source/sink.
- Buffers one prefetched input sample and registers the output sample.
- Converts the core's wide fixed-point result to the 32-bit output bus and throttles output rate with stall signals to the core.

Parameters:
- DW, 32, external sample width (io_in, io_out).
- ACC_W, 40, width of core output data (accumulator width, signed); must be >= DW.
- IN_LAT, 1, cycles after the req_in pulse cycle before io_in carries the new sample; range 1..15.
- OUT_GAP, 0, minimum idle cycles between consecutive out_en pulses; range 0..255.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- io_in  in  DW  signed sample from external source.
- req_in  out  2  input request strobe; 2'd1 = request next sample, 2'd0 = idle; 2'd2/2'd3 never driven.
- io_out  out  DW  signed output sample, registered.
- out_en  out  2  output strobe; 2'd1 = io_out valid this cycle, else 2'd0.
- core_in_rd  in  1  core executes an input read.
- core_in_data  out  DW  buffered input sample (in_buf).
- core_in_stall  out  1  in_buf not valid; core must hold the read.
- core_out_wr  in  1  core executes an output write.
- core_out_data  in  ACC_W  signed core result.
- core_out_stall  out  1  output gap counter busy; core must hold the write.

Behaviour:
- Reset: req_in=0, out_en=0, io_out=0, in_buf=0, buf_valid=0, gap counter=0, input FSM in S_LOAD. Reset asserted mid-operation aborts any pending request; no req_in pulse is emitted for a read consumed before reset.
- Source contract: the external source presents sample 0 on io_in before reset release. It advances io_in on the clock edge that ends a cycle with req_in==1.
- Input FSM states:
  - S_LOAD: first cycle after reset; capture io_in into in_buf, set buf_valid=1, go to S_IDLE.
  - S_IDLE: core_in_stall=0. On core_in_rd=1, the current in_buf is consumed, buf_valid is cleared, and the FSM goes to S_REQ.
  - S_REQ: req_in=2'd1 for exactly this one cycle. Load wait counter with IN_LAT and go to S_WAIT.
  - S_WAIT: decrement the wait counter each cycle. On the cycle it reaches 1, capture io_in into in_buf, set buf_valid=1, go to S_IDLE.
- Input timing: with IN_LAT=1, a read accepted in cycle t gives req_in high in t+1, capture at the end of t+2, and buf_valid/new data visible in t+3. Back-to-back read throughput is 1 sample per 3 cycles.
- core_in_stall = ~buf_valid. A core_in_rd asserted while stalled is ignored and is not queued.
- core_in_data always reflects in_buf, which holds its value until the next capture.
- Output path: a write is accepted when core_out_wr=1 and gap counter==0.
  - Next cycle: io_out <= conv(core_out_data), out_en=2'd1 for exactly one cycle, gap counter <= OUT_GAP.
  - Gap counter decrements by 1 per cycle to 0.
  - core_out_stall = (gap counter != 0). A write during stall is ignored.
  - With OUT_GAP=0 the output accepts one write per cycle, and consecutive out_en pulses are allowed.
  - io_out holds its last value between pulses.
- conv(): arithmetic on two's-complement signed values; default conversion is truncation to the low DW bits.
- Simultaneous core_in_rd and core_out_wr: the input and output paths are fully independent, and both are accepted in the same cycle.

Optional Feature:
- Macro: PROCM6_IO_SAT_EN.
- Defined: conv() saturates core_out_data to the signed DW range. Values above 2^(DW-1)-1 are clamped to 2^(DW-1)-1; values below -2^(DW-1) are clamped to -2^(DW-1). A sticky output sat_flag (1 bit, reset 0, cleared only by rst) is added and set on any clamped write.
- Undefined: plain truncation to the low DW bits; sat_flag port is absent.

Test Plan:
- Reset with io_in=17, then release and hold core_in_rd=0 -> core_in_data=17 from the 2nd cycle after release, core_in_stall=0, req_in=0 and out_en=0 throughout.
- IN_LAT=1, core_in_rd pulse at cycle t, io_in changes to -5 on the edge ending t+1 -> req_in=2'd1 only in t+1, stall in t+1..t+2, core_in_data=-5 and stall=0 at t+3.
- IN_LAT=3, core_in_rd held high continuously -> one req_in pulse every 5 cycles, no extra pulses, and each returned sample equals the io_in value present at capture.
- OUT_GAP=2, core_out_wr held high with data 100, 200, 300 -> out_en pulses 3 cycles apart, io_out=100/200/300, and core_out_stall high for 2 cycles after each accept.
- core_out_data=40'sh00_8000_0000 (2^31) -> io_out=32'h8000_0000 without the macro. With PROCM6_IO_SAT_EN: io_out=32'h7FFF_FFFF and sat_flag=1. A following write of -3 gives io_out=-3 with sat_flag still 1.
- Assert rst in the cycle req_in is high, with reads and writes also active -> next cycle req_in=0, out_en=0, io_out=0. The FSM restarts at S_LOAD, and no stale pulse appears after release.

Source files
------------

// File: rtl/procm6_io_ctrl.sv
// procm6_io_ctrl: core-side sample I/O controller (input prefetch FSM, gap-throttled output); define PROCM6_IO_SAT_EN for saturating output and sat_flag
module procm6_io_ctrl #(
  parameter int DW = 32,
  parameter int ACC_W = 40,
  parameter int IN_LAT = 1,
  parameter int OUT_GAP = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [DW-1:0]    io_in,
  output logic [1:0]              req_in,
  output logic signed [DW-1:0]    io_out,
  output logic [1:0]              out_en,
  input  logic                    core_in_rd,
  output logic signed [DW-1:0]    core_in_data,
  output logic                    core_in_stall,
  input  logic                    core_out_wr,
  input  logic signed [ACC_W-1:0] core_out_data,
  output logic                    core_out_stall
`ifdef PROCM6_IO_SAT_EN
  ,
  output logic                    sat_flag
`endif
);
  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_REQ, S_WAIT} state_t;
  state_t state;
  logic [3:0] wait_cnt;
  logic buf_valid;
  logic signed [DW-1:0] in_buf;
  logic [7:0] gap_cnt;
  logic wr_ok;
  logic signed [DW-1:0] conv_data;
  assign core_in_data = in_buf;
  assign core_in_stall = ~buf_valid;
  assign core_out_stall = gap_cnt != 8'd0;
  assign wr_ok = core_out_wr & ~core_out_stall;
`ifdef PROCM6_IO_SAT_EN
  logic ovf;
  always_comb begin
    ovf = ~(&core_out_data[ACC_W-1:DW-1] | ~|core_out_data[ACC_W-1:DW-1]);
    conv_data = ovf ? {core_out_data[ACC_W-1], {(DW-1){~core_out_data[ACC_W-1]}}} : core_out_data[DW-1:0];
  end
  always_ff @(posedge clk) sat_flag <= rst ? 1'b0 : sat_flag | (wr_ok & ovf);
`else
  logic unused_acc;
  assign unused_acc = ^core_out_data;
  assign conv_data = core_out_data[DW-1:0];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOAD;
      req_in <= 2'd0;
      wait_cnt <= 4'd0;
      buf_valid <= 1'b0;
      in_buf <= '0;
    end else begin
      req_in <= 2'd0;
      case (state)
        S_LOAD: begin
          in_buf <= io_in;
          buf_valid <= 1'b1;
          state <= S_IDLE;
        end
        S_IDLE: if (core_in_rd) begin
          buf_valid <= 1'b0;
          req_in <= 2'd1;
          state <= S_REQ;
        end
        S_REQ: begin
          wait_cnt <= 4'(IN_LAT);
          state <= S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            in_buf <= io_in;
            buf_valid <= 1'b1;
            state <= S_IDLE;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_en <= 2'd0;
      io_out <= '0;
      gap_cnt <= 8'd0;
    end else begin
      out_en <= wr_ok ? 2'd1 : 2'd0;
      io_out <= wr_ok ? conv_data : io_out;
      gap_cnt <= wr_ok ? 8'(OUT_GAP) : gap_cnt - {7'd0, core_out_stall};
    end
  end
endmodule

// File: tb/tb_procm6_io_ctrl.sv
// tb_procm6_io_ctrl: directed table and sequence checks of procm6_io_ctrl at IN_LAT=1/OUT_GAP=0 and IN_LAT=3/OUT_GAP=2
module tb_procm6_io_ctrl;
  logic clk = 1'b0;
  logic rst, rd, wr;
  logic signed [39:0] wd;
  logic signed [31:0] io_in1, io_in3, io_out1, io_out3, data1, data3;
  logic [1:0] req1, req3, oen1, oen3;
  logic istall1, istall3, ostall1, ostall3;
  int idx1, idx3, n_cmp, n_bad;
`ifdef PROCM6_IO_SAT_EN
  logic sat1, sat3;
  localparam logic signed [31:0] POS_BIG = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] NEG_BIG = 32'sh8000_0000;
`else
  localparam logic signed [31:0] POS_BIG = 32'sh8000_0000;
  localparam logic signed [31:0] NEG_BIG = 32'sh0000_0001;
`endif
  always #5 clk = ~clk;
  procm6_io_ctrl #(.DW(32), .ACC_W(40), .IN_LAT(1), .OUT_GAP(0)) d1 (
    .clk(clk), .rst(rst), .io_in(io_in1), .req_in(req1), .io_out(io_out1), .out_en(oen1),
    .core_in_rd(rd), .core_in_data(data1), .core_in_stall(istall1),
    .core_out_wr(wr), .core_out_data(wd), .core_out_stall(ostall1)
`ifdef PROCM6_IO_SAT_EN
    , .sat_flag(sat1)
`endif
  );
  procm6_io_ctrl #(.DW(32), .ACC_W(40), .IN_LAT(3), .OUT_GAP(2)) d3 (
    .clk(clk), .rst(rst), .io_in(io_in3), .req_in(req3), .io_out(io_out3), .out_en(oen3),
    .core_in_rd(rd), .core_in_data(data3), .core_in_stall(istall3),
    .core_out_wr(wr), .core_out_data(wd), .core_out_stall(ostall3)
`ifdef PROCM6_IO_SAT_EN
    , .sat_flag(sat3)
`endif
  );
  function automatic logic signed [31:0] s1(int k);
    return k == 0 ? 32'sd17 : k == 1 ? -32'sd5 : 32'(k * 11);
  endfunction
  function automatic logic signed [31:0] s3(int k);
    return k == 0 ? 32'sd17 : 32'(k * 1000);
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // one clock; the source models advance io_in on the edge that ends a req_in==1 cycle
  task automatic step();
    logic r1, r3;
    r1 = req1 == 2'd1;
    r3 = req3 == 2'd1;
    @(posedge clk);
    #1;
    if (r1) begin idx1++; io_in1 = s1(idx1); end
    if (r3) begin idx3++; io_in3 = s3(idx3); end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    rd = 1'b0;
    wr = 1'b0;
    wd = '0;
    step();
    step();
    idx1 = 0;
    idx3 = 0;
    io_in1 = s1(0);
    io_in3 = s3(0);
    chk("rst_req", 64'(req1), 64'd0);
    chk("rst_oen", 64'(oen1), 64'd0);
    chk("rst_io_out", 64'(io_out1), 64'd0);
    chk("rst_data", 64'(data1), 64'd0);
    chk("rst_istall", 64'(istall1), 64'd1);
    chk("rst_ostall", 64'(ostall3), 64'd0);
    rst = 1'b0;
  endtask
  typedef struct {
    logic rd;
    logic wr;
    logic signed [39:0] wd;
    logic [1:0] req;
    logic stall;
    logic signed [31:0] data;
    logic [1:0] oen;
    logic signed [31:0] io;
    logic sat;
  } vec_t;
  vec_t tv[12];
  int pulses;
  logic signed [31:0] outs[3];
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    n_cmp = 0;
    n_bad = 0;
    outs[0] = 32'sd100; outs[1] = 32'sd200; outs[2] = 32'sd300;
    tv[0]  = '{1'b0, 1'b0, 40'sd0, 2'd0, 1'b0, 32'sd17, 2'd0, 32'sd0, 1'b0};
    tv[1]  = '{1'b0, 1'b0, 40'sd0, 2'd0, 1'b0, 32'sd17, 2'd0, 32'sd0, 1'b0};
    tv[2]  = '{1'b1, 1'b1, 40'sd5, 2'd1, 1'b1, 32'sd17, 2'd1, 32'sd5, 1'b0};
    tv[3]  = '{1'b0, 1'b1, -40'sd7, 2'd0, 1'b1, 32'sd17, 2'd1, -32'sd7, 1'b0};
    tv[4]  = '{1'b0, 1'b0, 40'sd0, 2'd0, 1'b0, -32'sd5, 2'd0, -32'sd7, 1'b0};
    tv[5]  = '{1'b1, 1'b1, 40'sh00_8000_0000, 2'd1, 1'b1, -32'sd5, 2'd1, POS_BIG, 1'b1};
    tv[6]  = '{1'b1, 1'b1, -40'sd3, 2'd0, 1'b1, -32'sd5, 2'd1, -32'sd3, 1'b1};
    tv[7]  = '{1'b1, 1'b0, 40'sd0, 2'd0, 1'b0, 32'sd22, 2'd0, -32'sd3, 1'b1};
    tv[8]  = '{1'b0, 1'b0, 40'sd0, 2'd0, 1'b0, 32'sd22, 2'd0, -32'sd3, 1'b1};
    tv[9]  = '{1'b0, 1'b1, 40'shFF_0000_0001, 2'd0, 1'b0, 32'sd22, 2'd1, NEG_BIG, 1'b1};
    tv[10] = '{1'b0, 1'b1, 40'sh00_7FFF_FFFF, 2'd0, 1'b0, 32'sd22, 2'd1, 32'sh7FFF_FFFF, 1'b1};
    tv[11] = '{1'b0, 1'b1, 40'shFF_8000_0000, 2'd0, 1'b0, 32'sd22, 2'd1, 32'sh8000_0000, 1'b1};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      rd = tv[i].rd;
      wr = tv[i].wr;
      wd = tv[i].wd;
      step();
      chk($sformatf("v%0d_req", i), 64'(req1), 64'(tv[i].req));
      chk($sformatf("v%0d_istall", i), 64'(istall1), 64'(tv[i].stall));
      chk($sformatf("v%0d_data", i), 64'(data1), 64'(tv[i].data));
      chk($sformatf("v%0d_oen", i), 64'(oen1), 64'(tv[i].oen));
      chk($sformatf("v%0d_io_out", i), 64'(io_out1), 64'(tv[i].io));
      chk($sformatf("v%0d_ostall", i), 64'(ostall1), 64'd0);
`ifdef PROCM6_IO_SAT_EN
      chk($sformatf("v%0d_sat", i), 64'(sat1), 64'(tv[i].sat));
`endif
    end
    do_reset();
    rd = 1'b1;
    pulses = 0;
    for (int n = 1; n <= 24; n++) begin
      step();
      if (req3 == 2'd1) pulses++;
      chk($sformatf("lat3_req_%0d", n), 64'(req3), 64'((n >= 2 && (n - 2) % 5 == 0) ? 2'd1 : 2'd0));
      chk($sformatf("lat3_stall_%0d", n), 64'(istall3), 64'(n % 5 != 1));
      chk($sformatf("lat3_data_%0d", n), 64'(data3), 64'(s3((n - 1) / 5)));
    end
    chk("lat3_pulses", 64'(pulses), 64'd5);
    rd = 1'b0;
    wr = 1'b1;
    wd = 40'sd100;
    for (int n = 1; n <= 9; n++) begin
      step();
      chk($sformatf("gap2_oen_%0d", n), 64'(oen3), 64'((n % 3 == 1 && n <= 7) ? 2'd1 : 2'd0));
      chk($sformatf("gap2_stall_%0d", n), 64'(ostall3), 64'(n % 3 != 0));
      chk($sformatf("gap2_io_%0d", n), 64'(io_out3), 64'(outs[(n - 1) / 3]));
      if (n % 3 == 1) begin
        wd = n < 7 ? 40'(outs[(n + 2) / 3]) : 40'sd0;
        wr = n < 7;
      end
    end
    for (int n = 0; n < 4; n++) step();
    rd = 1'b1;
    wr = 1'b1;
    wd = 40'sd55;
    step();
    chk("pre_rst_req", 64'(req1), 64'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_req", 64'(req1), 64'd0);
    chk("mid_rst_oen", 64'(oen1), 64'd0);
    chk("mid_rst_io_out", 64'(io_out1), 64'd0);
    chk("mid_rst_oen3", 64'(oen3), 64'd0);
    idx1 = 0;
    idx3 = 0;
    io_in1 = s1(0);
    io_in3 = s3(0);
    rst = 1'b0;
    rd = 1'b0;
    wr = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      step();
      chk($sformatf("post_rst_req_%0d", n), 64'(req1), 64'd0);
      chk($sformatf("post_rst_oen_%0d", n), 64'(oen1), 64'd0);
      chk($sformatf("post_rst_req3_%0d", n), 64'(req3), 64'd0);
      chk($sformatf("post_rst_data_%0d", n), 64'(data1), 64'(s1(0)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
